ubcla_seq_sub: RTL and testbench



---
 rtl/ubcla_seq_sub.sv | 142 ++++++++++++++
 tb/tb_ubcla_seq_sub.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ubcla_seq_sub.sv
// ubcla_seq_sub: recovers Y = S - X (mod 2^WIDTH) over several cycles.
// Each cycle one CHUNK-bit carry look-ahead group computes S + ~X + carry.
// The carry reaches the next chunk only through the carry register.
// err flags a true difference that falls outside [0, 2^WIDTH).
module ubcla_seq_sub #(
  parameter int WIDTH = 15,
  parameter int CHUNK = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   S,
  input  logic [WIDTH-1:0] X,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject parameter sets where the chunk size does not divide the width.
  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("ubcla_seq_sub: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH:0]   s_reg;
  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic             err_reg;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] s_chunk;
  logic [CHUNK-1:0] x_chunk;
  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] y_chunk;
  logic             carry_out;
  logic             term;
  logic             acc;
  logic             last_chunk;

  assign last_chunk = (cnt == CW'(NCHUNK - 1));
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign Y          = y_reg;
  assign err        = err_reg;

  // One look-ahead group. Each carry is the OR of generate terms plus the
  // propagated carry-in, all in flat two-level form with no ripple chain.
  always_comb begin
    s_chunk = s_reg[cnt*CHUNK +: CHUNK];
    x_chunk = x_reg[cnt*CHUNK +: CHUNK];
    g       = s_chunk & ~x_chunk;
    p       = s_chunk ^ ~x_chunk;
    c       = '0;
    c[0]    = carry;
    term    = 1'b0;
    acc     = 1'b0;
    for (int j = 0; j < CHUNK; j++) begin
      term = carry;
      for (int m = 0; m <= j; m++) begin
        term = term & p[m];
      end
      acc = term;
      for (int i = 0; i <= j; i++) begin
        term = g[i];
        for (int m = i + 1; m <= j; m++) begin
          term = term & p[m];
        end
        acc = acc | term;
      end
      c[j+1] = acc;
    end
    y_chunk   = p ^ c[CHUNK-1:0];
    carry_out = c[CHUNK];
  end

  // Next-state logic: accept in IDLE, step through chunks in RUN, hold in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN:  if (last_chunk) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register. A reset in any state drops the current operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: capture the operands, then write one result chunk per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg   <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
      err_reg <= 1'b0;
      carry   <= 1'b1;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_reg <= S;
            x_reg <= X;
            carry <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          y_reg[cnt*CHUNK +: CHUNK] <= y_chunk;
          carry <= carry_out;
          if (last_chunk) begin
            // The result fits when the sum's top bit matches the final borrow.
            err_reg <= s_reg[WIDTH] ^ ~carry_out;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ubcla_seq_sub.sv
// Testbench for ubcla_seq_sub: directed vectors with a scoreboard queue.
module tb_ubcla_seq_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] S;
  logic [14:0] X;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] Y;
  logic        err;

  logic [15:0] sb[$];
  int          check_count = 0;
  int          pass_count  = 0;

  ubcla_seq_sub #(.WIDTH(15), .CHUNK(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .X(X),
    .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .err(err)
  );

  always #5 clk = ~clk;

  // Stops a hung run with a failure line.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Presents S/X until accepted; optionally pushes the expected result.
  task automatic applyStimulus(input logic [15:0] s, input logic [14:0] x,
                               input logic [14:0] ey, input logic ee, input bit expect_out);
    int n = 0;
    in_valid = 1'b1;
    S = s;
    X = x;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    end else if (expect_out) begin
      sb.push_back({ey, ee});
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every accepted result is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("result_Y", 32'(Y), 32'(e[15:1]));
        checkOutput("result_err", 32'(err), 32'(e[0]));
      end
    end
  end

  initial begin
    logic [14:0] held_y;
    logic        held_err;
    int          n;
    rst = 1'b1;
    in_valid = 1'b0;
    S = '0;
    X = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_Y", 32'(Y), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    @(posedge clk);
    #2;

    // Latency: accept at edge 0, result visible after edge 3, in_ready after edge 4.
    applyStimulus(16'h0005, 15'h0003, 15'h0002, 1'b0, 1'b1);
    @(negedge clk); checkOutput("lat_c0_valid", 32'(out_valid), 32'd0);
    @(negedge clk); checkOutput("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); checkOutput("lat_c2_valid", 32'(out_valid), 32'd0);
    @(negedge clk); checkOutput("lat_c3_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_c3_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); checkOutput("lat_c4_in_ready", 32'(in_ready), 32'd1);
    checkOutput("lat_c4_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #2;

    applyStimulus(16'h0020, 15'h0001, 15'h001F, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(16'hFFFE, 15'h7FFF, 15'h7FFF, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(16'h8000, 15'h0000, 15'h0000, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(16'h0003, 15'h0005, 15'h7FFE, 1'b1, 1'b1);
    waitDrain();
    applyStimulus(16'h1234, 15'h0234, 15'h1000, 1'b0, 1'b1);
    waitDrain();

    // Back-pressure: result must hold while out_ready stays low.
    out_ready = 1'b0;
    applyStimulus(16'h4321, 15'h0321, 15'h4000, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_valid_rise", 32'(out_valid), 32'd1);
    held_y = 15'h4000;
    held_err = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #2;
      in_valid = 1'b1;
      S = 16'h0100 + 16'(i);
      X = 15'h0011 * 15'(i + 1);
      @(negedge clk);
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_Y", 32'(Y), 32'(held_y));
      checkOutput("stall_err", 32'(err), 32'(held_err));
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
    end
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pop_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    applyStimulus(16'h0040, 15'h0010, 15'h0030, 1'b0, 1'b1);
    waitDrain();

    // Abort mid-RUN; the next transaction must start from a clean carry.
    applyStimulus(16'h0003, 15'h0005, 15'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_Y", 32'(Y), 32'd0);
    checkOutput("abort_err", 32'(err), 32'd0);
    @(posedge clk);
    #2;
    applyStimulus(16'h000A, 15'h0004, 15'h0006, 1'b0, 1'b1);
    waitDrain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
